// File: rtl/usbh_pkg.sv
// Shared definitions for the USB full-speed host datapath.
// Holds the packetizer state encoding, the CRC16 constants and the
// DATA0/DATA1 PID bytes. The RX checker uses the same definitions.
package usbh_pkg;

    // CRC16 as used on USB data packets. The register is kept in reflected
    // (LSB-first) form, so the polynomial 0x8005 appears bit-reversed as 0xA001.
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_R = 16'hA001;

    // Full PID bytes, with the check nibble already included.
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI
    } tx_state_t;

endpackage

// File: rtl/usbh_crc16.sv
// Purely combinational one-byte update of the USB CRC16 (reflected form).
// The bits of the byte are consumed LSB first, in the order they go on the wire.
// Ports:
//   crc_i  : current CRC register value
//   data_i : byte to fold into the CRC
//   crc_o  : CRC after the byte, not complemented
module usbh_crc16
    import usbh_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] w_crc;

    // Eight unrolled shift steps. The feedback is the register LSB XOR the data bit.
    always_comb begin
        w_crc = crc_i;
        for (int b = 0; b < 8; b++) begin
            if (w_crc[0] ^ data_i[b]) begin
                w_crc = (w_crc >> 1) ^ CRC16_POLY_R;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
    end

    assign crc_o = w_crc;

endmodule

// File: rtl/usbh_tx_packetizer.sv
// Transmit-side DATA packet builder for the USB full-speed host.
// On start_i it sends the PID byte. It then pops len_i payload bytes from the
// TX FIFO and appends the complemented CRC16, low byte first. If the FIFO runs
// dry mid-packet, it aborts the packet with a one-cycle underrun_o pulse.
// Ports:
//   clk_i, rst_i          : clock, async active-high reset
//   start_i, pid_i, len_i : packet request (sampled in IDLE only)
//   abort_i               : synchronous abort, back to IDLE
//   fifo_empty_i/data_i   : TX FIFO head; fifo_pop_o consumes the head
//   tx_valid_o/data_o/last_o, tx_ready_i : byte stream to the SIE
//   busy_o, done_o, underrun_o : status
module usbh_tx_packetizer
    import usbh_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [7:0]       pid_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    input  logic             fifo_empty_i,
    input  logic [7:0]       fifo_data_i,
    output logic             fifo_pop_o,
    output logic             tx_valid_o,
    output logic [7:0]       tx_data_o,
    output logic             tx_last_o,
    input  logic             tx_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             underrun_o
);

    tx_state_t        r_state, w_stateNext;
    logic [LEN_W-1:0] r_count, w_countNext;
    logic [15:0]      r_crc, w_crcNext;
    logic [7:0]       r_txData, w_txDataNext;
    logic             r_txValid, w_txValidNext;
    logic             r_txLast, w_txLastNext;
    logic             r_done, w_doneNext;
    logic             r_underrun, w_underrunNext;
    logic             w_hs;
    logic             w_refill;
    logic             w_pop;
    logic [15:0]      w_crcUpd;
    logic [LEN_W-1:0] w_lenClamped;

    usbh_crc16 u_crc16 (
        .crc_i  (r_crc),
        .data_i (fifo_data_i),
        .crc_o  (w_crcUpd)
    );

    assign w_hs         = r_txValid & tx_ready_i;
    assign w_lenClamped = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;

    // A payload byte is still owed and the output register is free, or it is
    // freed by this cycle's handshake. Refilling from PID too keeps the
    // stream gap-free between the PID and the first payload byte.
    assign w_refill = ((r_state == ST_PID) || (r_state == ST_DATA)) &&
                      (r_count != '0) && (!r_txValid || w_hs);

    // Next-state and next-output logic.
    always_comb begin
        w_stateNext    = r_state;
        w_countNext    = r_count;
        w_crcNext      = r_crc;
        w_txDataNext   = r_txData;
        w_txValidNext  = r_txValid;
        w_txLastNext   = r_txLast;
        w_doneNext     = 1'b0;
        w_underrunNext = 1'b0;
        w_pop          = 1'b0;

        if (abort_i) begin
            w_stateNext   = ST_IDLE;
            w_txValidNext = 1'b0;
            w_txLastNext  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        w_countNext   = w_lenClamped;
                        w_txDataNext  = pid_i;
                        w_txValidNext = 1'b1;
                        w_txLastNext  = 1'b0;
                        w_crcNext     = CRC16_INIT;
                        w_stateNext   = ST_PID;
                    end
                end
                ST_PID, ST_DATA: begin
                    if (w_refill) begin
                        if (!fifo_empty_i) begin
                            w_pop         = 1'b1;
                            w_txDataNext  = fifo_data_i;
                            w_txValidNext = 1'b1;
                            w_crcNext     = w_crcUpd;
                            w_countNext   = r_count - LEN_W'(1);
                            w_stateNext   = ST_DATA;
                        end else if (r_state == ST_DATA) begin
                            w_underrunNext = 1'b1;
                            w_txValidNext  = 1'b0;
                            w_stateNext    = ST_IDLE;
                        end else begin
                            // The PID went out but the FIFO is momentarily empty.
                            // DATA gets one more look before it declares underrun.
                            w_txValidNext = 1'b0;
                            w_stateNext   = ST_DATA;
                        end
                    end else if (w_hs) begin
                        // No payload bytes remain: either an empty packet's PID or
                        // the last payload byte was just accepted.
                        w_txDataNext  = ~r_crc[7:0];
                        w_txValidNext = 1'b1;
                        w_stateNext   = ST_CRC_LO;
                    end
                end
                ST_CRC_LO: begin
                    if (w_hs) begin
                        w_txDataNext = ~r_crc[15:8];
                        w_txLastNext = 1'b1;
                        w_stateNext  = ST_CRC_HI;
                    end
                end
                ST_CRC_HI: begin
                    if (w_hs) begin
                        w_txValidNext = 1'b0;
                        w_txLastNext  = 1'b0;
                        w_doneNext    = 1'b1;
                        w_stateNext   = ST_IDLE;
                    end
                end
                default: begin
                    w_stateNext   = ST_IDLE;
                    w_txValidNext = 1'b0;
                    w_txLastNext  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_crc      <= CRC16_INIT;
            r_txData   <= 8'h00;
            r_txValid  <= 1'b0;
            r_txLast   <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_count    <= w_countNext;
            r_crc      <= w_crcNext;
            r_txData   <= w_txDataNext;
            r_txValid  <= w_txValidNext;
            r_txLast   <= w_txLastNext;
            r_done     <= w_doneNext;
            r_underrun <= w_underrunNext;
        end
    end

    assign fifo_pop_o = w_pop;
    assign tx_valid_o = r_txValid;
    assign tx_data_o  = r_txData;
    assign tx_last_o  = r_txLast;
    assign busy_o     = (r_state != ST_IDLE);
    assign done_o     = r_done;
    assign underrun_o = r_underrun;

endmodule

// File: tb/tb_usbh_tx_packetizer.sv
// Testbench for usbh_tx_packetizer.
// The bench keeps a queue-based TX FIFO model in front of the packetizer.
// It builds the expected byte stream from the packet rules: the PID, the
// payload, then a bit-serial CRC16 computed in unreflected form. It compares
// every byte accepted on the tx stream against that stream.
module tb_usbh_tx_packetizer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pid;
    logic [6:0] len;
    logic       abort;
    logic       fifoEmpty;
    logic [7:0] fifoData;
    logic       fifoPop;
    logic       txValid;
    logic [7:0] txData;
    logic       txLast;
    logic       ready;
    logic       busy;
    logic       done;
    logic       underrun;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] fifoQ[$];
    logic [7:0] capData[$];
    logic       capLast[$];
    logic       popPending;
    int         popCount, doneCount, underrunCount, validCycles;
    int         firstValidStep, lastValidStep, stepIdx;
    logic       smpValid, smpLast, smpPop, smpBusy;
    logic [7:0] smpData;
    logic       prevValid, prevReady, prevLast;
    logic [7:0] prevData;

    always #5 clk = ~clk;

    usbh_tx_packetizer #(.MAX_LEN(64), .LEN_W(7)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .pid_i        (pid),
        .len_i        (len),
        .abort_i      (abort),
        .fifo_empty_i (fifoEmpty),
        .fifo_data_i  (fifoData),
        .fifo_pop_o   (fifoPop),
        .tx_valid_o   (txValid),
        .tx_data_o    (txData),
        .tx_last_o    (txLast),
        .tx_ready_i   (ready),
        .busy_o       (busy),
        .done_o       (done),
        .underrun_o   (underrun)
    );

    // Overall time limit, in case something escapes the per-packet budgets.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // USB CRC16 from first principles: bits are taken in wire order (LSB
    // first) through an unreflected 0x8005 register. The result is
    // bit-reversed and complemented.
    function automatic logic [15:0] modelCrc(input logic [7:0] q[$], input int n);
        logic [15:0] c;
        logic [15:0] r;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[15] ^ q[k][b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        for (int i = 0; i < 16; i++) r[i] = c[15-i];
        return ~r;
    endfunction

    task automatic syncFifo();
        fifoEmpty = (fifoQ.size() == 0);
        fifoData  = fifoEmpty ? 8'h00 : fifoQ[0];
    endtask

    task automatic clearHistory();
        prevValid  = 1'b0;
        prevReady  = 1'b0;
        prevLast   = 1'b0;
        prevData   = 8'h00;
        popPending = 1'b0;
    endtask

    task automatic startCapture();
        capData.delete();
        capLast.delete();
        popCount       = 0;
        doneCount      = 0;
        underrunCount  = 0;
        validCycles    = 0;
        firstValidStep = -1;
        lastValidStep  = -1;
        stepIdx        = 0;
    endtask

    // One clock: drive inputs at the falling edge, then sample just after it.
    // The sampled values are the ones the next rising edge will act on.
    task automatic applyStimulus(input logic iStart, input logic iAbort, input logic iReady);
        @(negedge clk);
        if (popPending) begin
            if (fifoQ.size() > 0) void'(fifoQ.pop_front());
            popPending = 1'b0;
            syncFifo();
        end
        start = iStart;
        abort = iAbort;
        ready = iReady;
        #1;
        smpValid = txValid;
        smpData  = txData;
        smpLast  = txLast;
        smpPop   = fifoPop;
        smpBusy  = busy;
        if (fifoEmpty) checkOutput("pop_on_empty", 32'(smpPop), 32'd0);
        if (smpValid && !iReady) checkOutput("pop_while_full", 32'(smpPop), 32'd0);
        if (prevValid && !prevReady) begin
            checkOutput("stall_valid", 32'(smpValid), 32'd1);
            checkOutput("stall_data", 32'(smpData), 32'(prevData));
            checkOutput("stall_last", 32'(smpLast), 32'(prevLast));
        end
        if (smpPop) begin
            popPending = 1'b1;
            popCount++;
        end
        if (smpValid && iReady) begin
            capData.push_back(smpData);
            capLast.push_back(smpLast);
        end
        if (smpValid) begin
            validCycles++;
            if (firstValidStep < 0) firstValidStep = stepIdx;
            lastValidStep = stepIdx;
        end
        if (done) doneCount++;
        if (underrun) underrunCount++;
        prevValid = smpValid && !iAbort;
        prevReady = iReady;
        prevData  = smpData;
        prevLast  = smpLast;
        stepIdx++;
    endtask

    // Run one packet end to end and score it against the model stream.
    task automatic runPacket(input string tag, input logic [7:0] iPid, input int iLen, input int iFifo,
                             input bit iFixed, input bit iRandReady, input bit iExtraStart);
        int         effLen, nSend, budget, nLast;
        bit         expUnder;
        logic [7:0] payload[$];
        logic [7:0] expQ[$];
        logic [15:0] crc;
        logic       r;
        effLen = (iLen > 64) ? 64 : iLen;
        fifoQ.delete();
        for (int i = 0; i < iFifo; i++) begin
            payload.push_back(iFixed ? 8'(8'h31 + i) : 8'($urandom));
            fifoQ.push_back(payload[i]);
        end
        syncFifo();
        expUnder = (iFifo < effLen);
        nSend    = expUnder ? iFifo : effLen;
        expQ.push_back(iPid);
        for (int i = 0; i < nSend; i++) expQ.push_back(payload[i]);
        if (!expUnder) begin
            crc = modelCrc(payload, effLen);
            expQ.push_back(crc[7:0]);
            expQ.push_back(crc[15:8]);
        end

        startCapture();
        pid = iPid;
        len = 7'(iLen);
        applyStimulus(1'b1, 1'b0, 1'b1);
        budget = 0;
        while ((doneCount + underrunCount) == 0 && budget < 600) begin
            r = iRandReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (iExtraStart && budget == 3) begin
                pid = 8'hAA;
                len = 7'd5;
                applyStimulus(1'b1, 1'b0, r);
            end else begin
                applyStimulus(1'b0, 1'b0, r);
            end
            if (budget == 0) begin
                checkOutput({tag, "_first_valid"}, 32'(smpValid), 32'd1);
                checkOutput({tag, "_first_pid"}, 32'(smpData), 32'(iPid));
                checkOutput({tag, "_busy"}, 32'(smpBusy), 32'd1);
            end
            budget++;
        end
        if (budget >= 600) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);

        checkOutput({tag, "_byte_count"}, 32'(capData.size()), 32'(expQ.size()));
        for (int i = 0; i < capData.size() && i < expQ.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(capData[i]), 32'(expQ[i]));
        nLast = 0;
        foreach (capLast[i]) if (capLast[i]) nLast++;
        checkOutput({tag, "_last_count"}, 32'(nLast), expUnder ? 32'd0 : 32'd1);
        if (!expUnder && capLast.size() > 0)
            checkOutput({tag, "_last_pos"}, 32'(capLast[capLast.size()-1]), 32'd1);
        checkOutput({tag, "_done"}, 32'(doneCount), expUnder ? 32'd0 : 32'd1);
        checkOutput({tag, "_underrun"}, 32'(underrunCount), expUnder ? 32'd1 : 32'd0);
        checkOutput({tag, "_pops"}, 32'(popCount), 32'(nSend));
        checkOutput({tag, "_fifo_left"}, 32'(fifoQ.size()), 32'(iFifo - nSend));
        checkOutput({tag, "_idle_valid"}, 32'(smpValid), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(smpBusy), 32'd0);
        if (!iRandReady && !expUnder) begin
            checkOutput({tag, "_valid_cycles"}, 32'(validCycles), 32'(effLen + 3));
            checkOutput({tag, "_valid_span"}, 32'(lastValidStep - firstValidStep + 1), 32'(effLen + 3));
        end
        fifoQ.delete();
        syncFifo();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_valid"}, 32'(txValid), 32'd0);
        checkOutput({tag, "_data"}, 32'(txData), 32'd0);
        checkOutput({tag, "_last"}, 32'(txLast), 32'd0);
        checkOutput({tag, "_pop"}, 32'(fifoPop), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    initial begin
        logic [7:0]  abortBytes[$];
        logic [7:0]  rstBytes[$];
        logic [15:0] crc;
        int          rl;

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b0;
        pid   = 8'h00;
        len   = 7'd0;
        fifoQ.delete();
        syncFifo();
        clearHistory();
        startCapture();
        repeat (3) @(negedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        rst = 1'b0;

        // Zero-length packet: PID and the CRC of nothing.
        runPacket("len0", 8'hC3, 0, 0, 1'b1, 1'b0, 1'b0);

        // The "123456789" check string, with back-to-back ready.
        runPacket("len9", 8'h4B, 9, 9, 1'b1, 1'b0, 1'b0);
        if (capData.size() == 12) begin
            checkOutput("len9_crc_lo_known", 32'(capData[10]), 32'h0000_00C8);
            checkOutput("len9_crc_hi_known", 32'(capData[11]), 32'h0000_00B4);
        end

        // The same packet with a stalling sink.
        runPacket("len9_stall", 8'h4B, 9, 9, 1'b1, 1'b1, 1'b0);

        // The FIFO runs dry after two of the four bytes.
        runPacket("underrun", 8'hC3, 4, 2, 1'b0, 1'b0, 1'b0);

        // Abort in the middle of the payload.
        fifoQ.delete();
        for (int i = 0; i < 8; i++) begin
            abortBytes.push_back(8'($urandom));
            fifoQ.push_back(abortBytes[i]);
        end
        syncFifo();
        startCapture();
        pid = 8'hC3;
        len = 7'd8;
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("abort_no_pop", 32'(smpPop), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_valid", 32'(smpValid), 32'd0);
        checkOutput("abort_last", 32'(smpLast), 32'd0);
        checkOutput("abort_busy", 32'(smpBusy), 32'd0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_bytes", 32'(capData.size()), 32'd5);
        if (capData.size() == 5) begin
            checkOutput("abort_pid", 32'(capData[0]), 32'h0000_00C3);
            for (int i = 0; i < 4; i++)
                checkOutput($sformatf("abort_byte%0d", i), 32'(capData[i+1]), 32'(abortBytes[i]));
        end
        checkOutput("abort_fifo_left", 32'(fifoQ.size()), 32'd4);
        if (fifoQ.size() > 0) checkOutput("abort_fifo_head", 32'(fifoQ[0]), 32'(abortBytes[4]));
        checkOutput("abort_status", 32'(doneCount + underrunCount), 32'd0);
        fifoQ.delete();
        syncFifo();

        // Reset while the CRC low byte is on the output.
        for (int i = 0; i < 2; i++) begin
            rstBytes.push_back(8'($urandom));
            fifoQ.push_back(rstBytes[i]);
        end
        syncFifo();
        crc = modelCrc(rstBytes, 2);
        startCapture();
        pid = 8'h4B;
        len = 7'd2;
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst_pre_crc_lo", 32'(smpData), 32'(crc[7:0]));
        rst = 1'b1;
        #1;
        checkResetValues("rst_async");
        @(negedge clk);
        rst = 1'b0;
        clearHistory();
        fifoQ.delete();
        syncFifo();
        runPacket("rst_recover", 8'hC3, 5, 5, 1'b0, 1'b0, 1'b0);

        // An oversize length with a stray start while busy.
        runPacket("len100", 8'h4B, 100, 64, 1'b0, 1'b0, 1'b1);

        // Random packets, some with an oversize length, all with a stalling sink.
        for (int n = 0; n < 4; n++) begin
            rl = int'($urandom_range(0, 80));
            runPacket($sformatf("rand%0d", n), ($urandom_range(0, 1) != 0) ? 8'hC3 : 8'h4B,
                      rl, (rl > 64) ? 64 : rl, 1'b0, 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usbh_tx_packetizer.md
# usbh_tx_packetizer

Transmit-side data packetizer for the USB full-speed host: on a start command it emits a DATA PID byte, pops exactly `len_i` payload bytes from the host TX byte FIFO, and appends the USB CRC16 (two bytes, low byte first). It sits between the TX FIFO, whose pop/empty/data port it consumes, and the SIE bit-level transmitter, which it feeds through a byte valid/ready stream. It also detects FIFO underrun mid-packet and aborts cleanly.

## Interface
- `MAX_LEN`, 64: maximum payload bytes per packet (full-speed bulk/interrupt max).
- `LEN_W`, 7: width of the length field; must hold `MAX_LEN`.
- `clk_i`  in  1  single block clock.
- `rst_i`  in  1  reset, asynchronous, active-high; one clock, no other clock domains.
- `start_i`  in  1  start-packet strobe; sampled only in IDLE.
- `pid_i`  in  8  full PID byte (PID + check nibble) sent first; not validated.
- `len_i`  in  LEN_W  payload length 0..MAX_LEN, captured with `start_i`; values > MAX_LEN are clamped to MAX_LEN.
- `abort_i`  in  1  synchronous abort; highest priority after reset.
- `fifo_empty_i`  in  1  TX FIFO empty flag.
- `fifo_data_i`  in  8  TX FIFO head byte (combinational read of head entry).
- `fifo_pop_o`  out  1  pop strobe; head byte is consumed on the same edge.
- `tx_valid_o`  out  1  output byte valid.
- `tx_data_o`  out  8  output byte.
- `tx_last_o`  out  1  marks the final byte (CRC high byte) of the packet.
- `tx_ready_i`  in  1  SIE accepts the byte when `tx_valid_o & tx_ready_i` at a rising edge.
- `busy_o`  out  1  high from the cycle after start acceptance until return to IDLE.
- `done_o`  out  1  one-cycle pulse: packet completed normally.
- `underrun_o`  out  1  one-cycle pulse: packet aborted because the FIFO ran dry.

## Operation
- States: IDLE, PID, DATA, CRC_LO, CRC_HI.
- IDLE: `start_i` captures `len_i` into the down-counter and loads `pid_i` into the output register. It sets `tx_valid_o`, loads CRC to 0xFFFF, and moves to PID.
- PID: on handshake, go to DATA if the count is nonzero, else CRC_LO. The PID is excluded from the CRC.
- DATA: the output register is refilled when it is empty or being handshaken in the current cycle.
  - A refill needs `!fifo_empty_i`. It asserts `fifo_pop_o`, latches `fifo_data_i`, updates the CRC with that byte, and decrements the count.
  - When the handshake of the last payload byte occurs, go to CRC_LO.
  - Underrun: a refill is needed, the count is nonzero, and `fifo_empty_i` is high. Response: pulse `underrun_o`, drop `tx_valid_o`, return to IDLE. There is no `done_o` and no pop.
- CRC_LO / CRC_HI: send `~crc[7:0]`, then `~crc[15:8]`. CRC_HI also asserts `tx_last_o`. The CRC_HI handshake pulses `done_o` and returns to IDLE.
- CRC16: reflected polynomial 0xA001 (0x8005), init 0xFFFF, processed LSB-first per byte, output complemented.
- `abort_i` in any state: return to IDLE next cycle with `tx_valid_o`, `tx_last_o`, and `fifo_pop_o` low. No status pulses are generated. Unsent FIFO bytes stay in the FIFO; flushing it is the caller's job.
- `start_i` outside IDLE is ignored.

## Timing
- Reset values: `tx_valid_o`=0, `tx_data_o`=0x00, `tx_last_o`=0, `fifo_pop_o`=0, `busy_o`=0, `done_o`=0, `underrun_o`=0, state IDLE, count 0, CRC 0xFFFF.
- `start_i` at edge N produces `tx_valid_o`=1 with the PID after edge N.
- `tx_data_o` and `tx_last_o` are registered and hold stable while `tx_valid_o & !tx_ready_i`.
- `fifo_pop_o` is combinational from state, count, `fifo_empty_i`, and the refill condition. It is never asserted when `fifo_empty_i`=1.
- With `tx_ready_i` held high, the block sustains one byte per clock: a packet of L payload bytes takes L+3 cycles from the first `tx_valid_o`.
- `done_o` and `underrun_o` are registered, asserted in the cycle after the triggering edge.
- A new `start_i` may be accepted in the cycle `done_o` is high.

## Structure
- Shared package `usbh_pkg`: state enum, `CRC16_INIT`=16'hFFFF, `CRC16_POLY_R`=16'hA001, and the DATA0/DATA1 PID constants (0xC3/0x4B).
- One sub-module, `usbh_crc16`: purely combinational byte update, `crc_o = f(crc_i, data_i)`. It is reused by the RX checker.

## Test plan
- PID 0xC3, len 0, ready held high: byte stream C3, 00, 00; `tx_last_o` on the third byte; `done_o` pulse; zero pops.
- PID 0x4B, len 9, FIFO preloaded with 0x31..0x39, ready high: byte stream 4B, 31..39, C8, B4; 9 pops; 12 valid cycles back-to-back.
- Same packet with `tx_ready_i` randomly deasserted 50% of the time: identical byte sequence. The bench checks data stability while stalled and that no pop occurs while the output register is full.
- len 4 with only 2 bytes in the FIFO: stream is PID, byte0, byte1; `underrun_o` pulses once, `tx_valid_o` drops, no `done_o`, FIFO left empty, block returns to IDLE.
- `abort_i` mid-DATA, then `rst_i` asserted mid-CRC_LO on a second packet: outputs return to their reset values immediately on `rst_i`. The next start produces a correct packet.
- `start_i` pulsed while busy, and len 100 (above MAX_LEN): the extra start is ignored; the oversize length sends exactly 64 payload bytes.
